serdes_1to10_align: RTL

- Receive-side word aligner for the 10:1 TMDS/serial links driven by the serializer TX block.
- Takes 10-bit words from a 1:10 deserializer whose word boundary is at an arbitrary bit phase. Finds the boundary by locking onto TMDS control tokens in a 20-bit sliding window.
- Outputs aligned 10-bit symbols plus lock status, for the downstream TMDS decoder.
- Bit order matches the TX: bit 0 is the first bit on the wire.

---
 rtl/serdes_pkg.sv | 11 +
 rtl/serdes_1to10_align.sv | 72 +++++++
 2 files changed

// File: rtl/serdes_pkg.sv
// serdes_pkg: TMDS control tokens, token matcher and aligner state encoding
package serdes_pkg;
  localparam logic [9:0] CTRL_0 = 10'h354;
  localparam logic [9:0] CTRL_1 = 10'h0AB;
  localparam logic [9:0] CTRL_2 = 10'h154;
  localparam logic [9:0] CTRL_3 = 10'h2AB;
  typedef enum logic {SEARCH, LOCKED} state_t;
  function automatic logic is_ctrl_token(input logic [9:0] s);
    return s == CTRL_0 || s == CTRL_1 || s == CTRL_2 || s == CTRL_3;
  endfunction
endpackage

// File: rtl/serdes_1to10_align.sv
// serdes_1to10_align: finds the 10-bit word boundary by locking onto TMDS control tokens
module serdes_1to10_align
  import serdes_pkg::*;
#(
  parameter int LOCK_TOKENS    = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 8192
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] i_data,
  output logic [9:0] o_data,
  output logic       o_token,
  output logic       o_locked,
  output logic [3:0] o_offset
);
  localparam int RW = $clog2(LOCK_TOKENS) + 1;
  localparam int DW = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int LW = $clog2(LOSS_TIMEOUT) + 1;
  localparam logic [RW-1:0] RUN_LOCK  = RW'(LOCK_TOKENS - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(SEARCH_TIMEOUT - 1);
  localparam logic [LW-1:0] LOSS_MAX  = LW'(LOSS_TIMEOUT - 1);
  logic [9:0] prev;
  logic [19:0] w;
  logic [9:0] cand;
  logic tok;
  logic [RW-1:0] run;
  logic [DW-1:0] dwell;
  logic [LW-1:0] loss;
  state_t state;
  assign w    = {i_data, prev};
  assign cand = w[{1'b0, o_offset} +: 10];
  assign tok  = is_ctrl_token(cand);
  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= '0;
      o_data   <= '0;
      o_token  <= 1'b0;
      o_locked <= 1'b0;
      o_offset <= '0;
      state    <= SEARCH;
      run      <= '0;
      dwell    <= '0;
      loss     <= '0;
    end else begin
      prev    <= i_data;
      o_data  <= cand;
      o_token <= tok;
      if (state == SEARCH) begin
        dwell <= &dwell ? dwell : dwell + 1'b1;
        run   <= !tok ? '0 : &run ? run : run + 1'b1;
        if (tok && run == RUN_LOCK) begin
          state    <= LOCKED;
          o_locked <= 1'b1;
          loss     <= '0;
        end else if (dwell == DWELL_MAX) begin
          o_offset <= o_offset == 4'd9 ? 4'd0 : o_offset + 4'd1;
          dwell    <= '0;
          run      <= '0;
        end
      end else begin
        loss <= tok ? '0 : &loss ? loss : loss + 1'b1;
        if (!tok && loss == LOSS_MAX) begin
          state    <= SEARCH;
          o_locked <= 1'b0;
          dwell    <= '0;
          run      <= '0;
        end
      end
    end
  end
endmodule
